pc_redirect_ctrl: RTL and testbench

- Owns the fetch PC register and sequences every control-flow redirect produced by the execute-stage branch logic (taken flag plus 32-bit target).
- Generates the flush pulses for the F/D and D/X latches.
- If a redirect arrives during a pipeline stall, it holds the redirect until the stall clears.
- After each redirect it masks branch requests from squashed instructions.
- Sits between the execute-stage branch unit and the fetch stage / instruction memory address port.

---
 rtl/pc_redirect_ctrl_pkg.sv | 16 +
 rtl/pc_redirect_ctrl_sat.sv | 26 ++
 rtl/pc_redirect_ctrl.sv | 117 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Processor-wide definitions shared by the fetch redirect logic:
// redirect FSM state encodings, reset PC default and the nop word.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HELD   = 2'b01,
    ST_SHADOW = 2'b10
  } rd_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Word the F/D and D/X latches load when flushed.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_ctrl_sat.sv
// sat_counter: W-bit up counter, sync active-high reset, sticks at all-ones.
// Ports: clk_i, rst_i, inc_i (count enable), count_o (current value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequences execute-stage redirects, defers them across
// stalls, flushes F/D and D/X, and masks requests from squashed slots.
// Ports: clock, reset (sync, active-high), stall, branch_taken,
// branch_target -> pc, pc_plus1, fetch_en, flush_fd, flush_dx,
// redirect_count.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int                  PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = PC_WIDTH'(RESET_PC_DEF),
  parameter int                  SHADOW_CYCLES = 2,
  parameter int                  CNT_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_plus1,
  output logic                 fetch_en,
  output logic                 flush_fd,
  output logic                 flush_dx,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  localparam int SW =
    (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);
  localparam logic [SW-1:0] SHD_INIT = SW'(SHADOW_CYCLES);

  rd_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;
  logic [SW-1:0]       shd_q, shd_d;
  logic [PC_WIDTH-1:0] tgt;
  logic                commit;
  logic                unused_tgt;

  assign tgt        = branch_target[PC_WIDTH-1:0];
  assign unused_tgt = ^branch_target;
  assign pc_plus1   = pc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    shd_d   = shd_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          if (stall) begin
            pend_d  = tgt;
            state_d = ST_HELD;
          end else begin
            commit = 1'b1;
            pc_d   = tgt;
          end
        end else if (!stall) begin
          pc_d = pc_plus1;
        end
      end
      ST_HELD: begin
        // execute re-presents the same request; use the captured one
        if (!stall) begin
          commit = 1'b1;
          pc_d   = pend_q;
        end
      end
      ST_SHADOW: begin
        if (!stall) begin
          pc_d = pc_plus1;
          if (shd_q <= SW'(1)) begin
            shd_d   = '0;
            state_d = ST_RUN;
          end else begin
            shd_d = shd_q - 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (commit) begin
      shd_d   = SHD_INIT;
      state_d = (SHADOW_CYCLES == 0) ? ST_RUN : ST_SHADOW;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      shd_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      shd_q   <= shd_d;
    end
  end

  sat_counter #(
    .W(CNT_WIDTH)
  ) u_cnt (
    .clk_i  (clock),
    .rst_i  (reset),
    .inc_i  (commit),
    .count_o(redirect_count)
  );

  assign pc       = pc_q;
  assign fetch_en = ~stall & ~reset;
  assign flush_fd = commit & ~reset;
  assign flush_dx = commit & ~reset;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: a 32-bit/16-bit instance and a 4-bit/4-bit
// instance share stimulus and are checked against one behavioural model.
module tb_pc_redirect_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  logic [31:0] pc_a, pc1_a;
  logic        fe_a, ffd_a, fdx_a;
  logic [15:0] cnt_a;
  logic [3:0]  pc_b, pc1_b;
  logic        fe_b, ffd_b, fdx_b;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  pc_redirect_ctrl u_a (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc_a),
    .pc_plus1      (pc1_a),
    .fetch_en      (fe_a),
    .flush_fd      (ffd_a),
    .flush_dx      (fdx_a),
    .redirect_count(cnt_a)
  );

  pc_redirect_ctrl #(
    .PC_WIDTH (4),
    .CNT_WIDTH(4)
  ) u_b (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc_b),
    .pc_plus1      (pc1_b),
    .fetch_en      (fe_b),
    .flush_fd      (ffd_b),
    .flush_dx      (fdx_b),
    .redirect_count(cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: a fetch address, a count of redirects, a number of
  // slots still to squash, and a deferred request waiting on the stall.
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_sq;
  bit          m_wait;
  logic [31:0] m_pend;
  bit          m_valid = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_pc = 0; m_cnt = 0; m_sq = 0; m_wait = 0; m_pend = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_sq > 0) begin
        if (!stall) begin m_pc = m_pc + 1; m_sq = m_sq - 1; end
      end else if (m_wait) begin
        if (!stall) begin
          m_pc = m_pend; m_cnt++; m_sq = 2; m_wait = 0;
        end
      end else if (branch_taken) begin
        if (stall) begin m_wait = 1; m_pend = branch_target; end
        else begin m_pc = branch_target; m_cnt++; m_sq = 2; end
      end else if (!stall) begin
        m_pc = m_pc + 1;
      end
    end
  end

  always @(negedge clock) begin
    logic        efl, efe;
    logic [31:0] ep1;
    if (m_valid) begin
      efe = !reset && !stall;
      efl = !reset && !stall && (m_sq == 0) && (m_wait || branch_taken);
      ep1 = m_pc + 32'd1;
      chk("pc_a",    pc_a,  m_pc);
      chk("pc1_a",   pc1_a, ep1);
      chk("fe_a",    {31'b0, fe_a},  {31'b0, efe});
      chk("ffd_a",   {31'b0, ffd_a}, {31'b0, efl});
      chk("fdx_a",   {31'b0, fdx_a}, {31'b0, efl});
      chk("cnt_a",   {16'b0, cnt_a}, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("pc_b",    {28'b0, pc_b},  m_pc & 32'hF);
      chk("pc1_b",   {28'b0, pc1_b}, ep1 & 32'hF);
      chk("fe_b",    {31'b0, fe_b},  {31'b0, efe});
      chk("ffd_b",   {31'b0, ffd_b}, {31'b0, efl});
      chk("fdx_b",   {31'b0, fdx_b}, {31'b0, efl});
      chk("cnt_b",   {28'b0, cnt_b}, (m_cnt > 15) ? 15 : m_cnt);
    end
  end

  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic [31:0] t);
    @(posedge clock);
    #1;
    reset = r; stall = s; branch_taken = b; branch_target = t;
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_fe", {31'b0, fe_a}, 0);
    chk("rst_fl", {31'b0, ffd_a}, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk("run_pc", pc_a, i);
      chk("run_fl", {31'b0, ffd_a | fdx_a}, 0);
    end
    cyc(0, 0, 1, 32'h40);
    chk("rd_pc", pc_a, 4);
    chk("rd_fl", {31'b0, ffd_a & fdx_a}, 1);
    cyc(0, 0, 1, 32'h99);
    chk("sh0_pc", pc_a, 32'h40);
    chk("sh0_fl", {31'b0, ffd_a}, 0);
    chk("sh0_cnt", {16'b0, cnt_a}, 1);
    cyc(0, 0, 1, 32'h99);
    chk("sh1_pc", pc_a, 32'h41);
    chk("sh1_fl", {31'b0, ffd_a}, 0);
    cyc(0, 0, 1, 32'h99);
    chk("sh2_pc", pc_a, 32'h42);
    chk("sh2_fl", {31'b0, ffd_a}, 1);
    cyc(0, 0, 0, 0);
    chk("rd2_pc", pc_a, 32'h99);
    chk("rd2_cnt", {16'b0, cnt_a}, 2);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 32'h10);
      chk("stl_pc", pc_a, 32'h9b);
      chk("stl_fl", {31'b0, ffd_a}, 0);
      chk("stl_fe", {31'b0, fe_a}, 0);
    end
    cyc(0, 0, 1, 32'h10);
    chk("rel_fl", {31'b0, ffd_a}, 1);
    chk("rel_pc", pc_a, 32'h9b);
    cyc(0, 0, 0, 0);
    chk("held_pc", pc_a, 32'h10);
    chk("held_cnt", {16'b0, cnt_a}, 3);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h20);
    cyc(1, 1, 1, 32'h20);
    chk("rsth_fe", {31'b0, fe_a}, 0);
    chk("rsth_fl", {31'b0, ffd_a}, 0);
    for (int i = 0; i < 18; i++) begin
      cyc(0, 0, 0, 0);
      chk("wrap_pc_a", pc_a, i);
      chk("wrap_pc_b", {28'b0, pc_b}, i & 15);
      chk("wrap_cnt", {16'b0, cnt_a}, 0);
    end
    for (int k = 0; k < 19; k++) begin
      cyc(0, 0, 1, 32'h100);
      chk("sat_fl", {31'b0, ffd_b}, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("sat_cnt_a", {16'b0, cnt_a}, 19);
    chk("sat_cnt_b", {28'b0, cnt_b}, 15);
    cyc(0, 0, 1, 32'h102);
    chk("self_pc", pc_a, 32'h102);
    chk("self_fl", {31'b0, ffd_a}, 1);
    cyc(0, 0, 0, 0);
    chk("self_pc2", pc_a, 32'h102);
    chk("self_cnt", {16'b0, cnt_a}, 20);
    chk("self_cnt_b", {28'b0, cnt_b}, 15);
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 35,
          $urandom);
    end
    cyc(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
